// File: rtl/kempston_mouse.sv
// PS/2 mouse front end presenting Kempston mouse ports to the Z80.
// Enables streaming, decodes 3-byte packets, keeps X/Y and button state.
module kempston_mouse #(
    parameter int INIT_DELAY     = 3500000,
    parameter int INHIBIT_CYCLES = 700,
    parameter int FRAME_TIMEOUT  = 14000,
    parameter int ACK_TIMEOUT    = 350000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2clk_in,
    output logic        ps2clk_oe,
    input  logic        ps2data_in,
    output logic        ps2data_oe,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    output logic [7:0]  dout,
    output logic        oe_n,
    output logic        mouse_present
);

    localparam int HMAX0 = INIT_DELAY > ACK_TIMEOUT ? INIT_DELAY : ACK_TIMEOUT;
    localparam int HMAX  = HMAX0 > INHIBIT_CYCLES ? HMAX0 : INHIBIT_CYCLES;
    localparam int TW    = $clog2(HMAX + 1);
    localparam int FW    = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [7:0] CMD = 8'hF4;

    typedef enum logic [2:0] {
        INIT_WAIT, INHIBIT, REQ, TX, TX_ACK, WAIT_FA, STREAM
    } host_t;

    typedef enum logic [1:0] {B0, B1, B2} pkt_t;

    host_t state;
    pkt_t  pstate;

    logic [1:0]    clk_sync, data_sync;
    logic [7:0]    clk_hist;
    logic          filt, fall, data_s;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_sh;
    logic          par_ok, rx_valid, rx_err, rx_en;
    logic [FW-1:0] fr_cnt;
    logic [TW-1:0] tmr;
    logic [3:0]    tx_cnt;
    logic [7:0]    x, y, dx;
    logic [2:0]    btn, b0_btn;
    logic          b0_xo, b0_yo;

    assign data_s = data_sync[1];
    assign fall   = filt && (clk_hist == 8'h00);
    assign rx_en  = (state == WAIT_FA) || (state == STREAM);

    // Clock is debounced; data only needs synchronising since it is sampled mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_hist  <= 8'hFF;
            filt      <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2clk_in};
            data_sync <= {data_sync[0], ps2data_in};
            clk_hist  <= {clk_hist[6:0], clk_sync[1]};
            if (clk_hist == 8'hFF) filt <= 1'b1;
            else if (clk_hist == 8'h00) filt <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_sh    <= '0;
            par_ok   <= 1'b0;
            fr_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (!rx_en) begin
                bit_cnt <= '0;
                fr_cnt  <= '0;
            end else if (fall) begin
                fr_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!data_s) bit_cnt <= 4'd1;
                    else rx_err <= 1'b1;
                end else if (bit_cnt <= 4'd8) begin
                    rx_sh   <= {data_s, rx_sh[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_ok  <= ^{data_s, rx_sh};
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= '0;
                    if (data_s && par_ok) rx_valid <= 1'b1;
                    else rx_err <= 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (fr_cnt == FW'(FRAME_TIMEOUT - 1)) begin
                    rx_err  <= 1'b1;
                    bit_cnt <= '0;
                    fr_cnt  <= '0;
                end else begin
                    fr_cnt <= fr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT_WAIT;
            tmr           <= '0;
            tx_cnt        <= '0;
            ps2clk_oe     <= 1'b0;
            ps2data_oe    <= 1'b0;
            mouse_present <= 1'b0;
        end else begin
            unique case (state)
                INIT_WAIT: begin
                    if (tmr == TW'(INIT_DELAY - 1)) begin
                        tmr       <= '0;
                        ps2clk_oe <= 1'b1;
                        state     <= INHIBIT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                INHIBIT: begin
                    if (tmr == TW'(INHIBIT_CYCLES - 1)) begin
                        tmr        <= '0;
                        ps2data_oe <= 1'b1;
                        state      <= REQ;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                REQ: begin
                    ps2clk_oe <= 1'b0;
                    tx_cnt    <= '0;
                    state     <= TX;
                end
                TX: begin
                    if (fall) begin
                        tx_cnt <= tx_cnt + 4'd1;
                        if (tx_cnt < 4'd8) begin
                            ps2data_oe <= ~CMD[tx_cnt[2:0]];
                        end else if (tx_cnt == 4'd8) begin
                            ps2data_oe <= ^CMD;
                        end else begin
                            ps2data_oe <= 1'b0;
                            state      <= TX_ACK;
                        end
                    end
                end
                TX_ACK: begin
                    if (fall) begin
                        tmr <= '0;
                        if (!data_s) begin
                            state <= WAIT_FA;
                        end else begin
                            ps2clk_oe <= 1'b1;
                            state     <= INHIBIT;
                        end
                    end
                end
                WAIT_FA: begin
                    if (rx_valid && rx_sh == 8'hFA) begin
                        mouse_present <= 1'b1;
                        state         <= STREAM;
                    end else if (rx_valid || tmr == TW'(ACK_TIMEOUT - 1)) begin
                        tmr       <= '0;
                        ps2clk_oe <= 1'b1;
                        state     <= INHIBIT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                STREAM: ;
                default: state <= INIT_WAIT;
            endcase
        end
    end

    // Sign bits are irrelevant: counters wrap modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate <= B0;
            x      <= '0;
            y      <= '0;
            dx     <= '0;
            btn    <= '0;
            b0_btn <= '0;
            b0_xo  <= 1'b0;
            b0_yo  <= 1'b0;
        end else if (state != STREAM || rx_err) begin
            pstate <= B0;
        end else if (rx_valid) begin
            unique case (pstate)
                B0: begin
                    if (rx_sh[3]) begin
                        b0_btn <= rx_sh[2:0];
                        b0_xo  <= rx_sh[6];
                        b0_yo  <= rx_sh[7];
                        pstate <= B1;
                    end
                end
                B1: begin
                    dx     <= rx_sh;
                    pstate <= B2;
                end
                B2: begin
                    if (!b0_xo) x <= x + dx;
                    if (!b0_yo) y <= y + rx_sh;
                    btn    <= b0_btn;
                    pstate <= B0;
                end
                default: pstate <= B0;
            endcase
        end
    end

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (!iorq_n && !rd_n && a[7:0] == 8'hDF) begin
            case (a[15:8])
                8'hFB: begin
                    dout = x;
                    oe_n = 1'b0;
                end
                8'hFF: begin
                    dout = y;
                    oe_n = 1'b0;
                end
                8'hFA: begin
                    dout = {5'b11111, ~btn[2], ~btn[0], ~btn[1]};
                    oe_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kempston_mouse.sv
// Directed bench for kempston_mouse: init handshake, retry, packets, reads.
module tb_kempston_mouse;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2clk_in, ps2clk_oe, ps2data_in, ps2data_oe;
    logic [15:0] a = 16'h0000;
    logic        iorq_n = 1'b1;
    logic        rd_n = 1'b1;
    logic [7:0]  dout;
    logic        oe_n, mouse_present;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign ps2clk_in  = ps2clk_oe ? 1'b0 : dev_clk;
    assign ps2data_in = ps2data_oe ? 1'b0 : dev_data;

    kempston_mouse #(
        .INIT_DELAY(10),
        .INHIBIT_CYCLES(20),
        .FRAME_TIMEOUT(200),
        .ACK_TIMEOUT(3000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2clk_in(ps2clk_in),
        .ps2clk_oe(ps2clk_oe),
        .ps2data_in(ps2data_in),
        .ps2data_oe(ps2data_oe),
        .a(a),
        .iorq_n(iorq_n),
        .rd_n(rd_n),
        .dout(dout),
        .oe_n(oe_n),
        .mouse_present(mouse_present)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_rd(input string tag, input logic [15:0] addr,
                          input logic [7:0] ed, input logic eoe);
        @(negedge clk);
        a = addr;
        iorq_n = 1'b0;
        rd_n = 1'b0;
        #1;
        chk({tag, "_oe"}, 16'(oe_n), 16'(eoe));
        chk({tag, "_d"}, 16'(dout), 16'(ed));
        @(negedge clk);
        iorq_n = 1'b1;
        rd_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit badp);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ badp, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_data = fr[i];
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        dev_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    // Device side of a host-to-device transfer; expects 0xF4 with parity 0.
    task automatic host_hs();
        int n;
        logic [7:0] cmd;
        logic exp;
        cmd = 8'hF4;
        n = 0;
        while (!ps2clk_oe && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ps2clk_oe) begin
            chk("inhibit_timeout", 16'(ps2clk_oe), 16'd1);
            return;
        end
        n = 0;
        while (!ps2data_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("inhibit_len", 16'(n), 16'd20);
        chk("req_clk_held", 16'(ps2clk_oe), 16'd1);
        @(negedge clk);
        chk("tx_clk_rel", 16'(ps2clk_oe), 16'd0);
        chk("tx_start", 16'(ps2data_oe), 16'd1);
        repeat (20) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
            if (k < 8) exp = ~cmd[k];
            else if (k == 8) exp = 1'b1;
            else exp = 1'b0;
            chk($sformatf("tx_bit%0d", k), 16'(ps2data_oe), 16'(exp));
        end
        dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] ex,
                       input logic [7:0] ey, input logic [7:0] eb);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        cpu_rd($sformatf("x_%h%h%h", b0, b1, b2), 16'hFBDF, ex, 1'b0);
        cpu_rd($sformatf("y_%h%h%h", b0, b1, b2), 16'hFFDF, ey, 1'b0);
        cpu_rd($sformatf("b_%h%h%h", b0, b1, b2), 16'hFADF, eb, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 16'(ps2clk_oe), 16'd0);
        chk("rst_data_oe", 16'(ps2data_oe), 16'd0);
        chk("rst_present", 16'(mouse_present), 16'd0);
        chk("rst_idle_oe_n", 16'(oe_n), 16'd1);
        cpu_rd("rst_x", 16'hFBDF, 8'h00, 1'b0);
        cpu_rd("rst_y", 16'hFFDF, 8'h00, 1'b0);
        cpu_rd("rst_b", 16'hFADF, 8'hFF, 1'b0);
        cpu_rd("rst_other", 16'h00DF, 8'hFF, 1'b1);
        rst = 1'b0;

        host_hs();
        fork
            send_byte(8'hFE, 1'b0);
            host_hs();
        join
        chk("no_present_after_fe", 16'(mouse_present), 16'd0);
        send_byte(8'hFA, 1'b0);
        chk("present", 16'(mouse_present), 16'd1);
        chk("stream_clk_oe", 16'(ps2clk_oe), 16'd0);
        chk("stream_data_oe", 16'(ps2data_oe), 16'd0);

        pkt(8'h09, 8'h05, 8'hFD, 8'h05, 8'hFD, 8'hFD);
        pkt(8'h0E, 8'h00, 8'h00, 8'h05, 8'hFD, 8'hFA);
        pkt(8'h18, 8'hF9, 8'h00, 8'hFE, 8'hFD, 8'hFF);
        pkt(8'h08, 8'h03, 8'h00, 8'h01, 8'hFD, 8'hFF);
        pkt(8'h18, 8'hFE, 8'h00, 8'hFF, 8'hFD, 8'hFF);
        send_byte(8'h08, 1'b0);
        send_byte(8'h55, 1'b1);
        pkt(8'h08, 8'h01, 8'h01, 8'h00, 8'hFE, 8'hFF);
        send_byte(8'h00, 1'b0);
        pkt(8'h08, 8'h02, 8'h03, 8'h02, 8'h01, 8'hFF);
        pkt(8'h48, 8'h10, 8'h02, 8'h02, 8'h03, 8'hFF);
        cpu_rd("other_port", 16'hFBDE, 8'hFF, 1'b1);

        dev_data = 1'b0;
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_clk_oe", 16'(ps2clk_oe), 16'd0);
        chk("midrst_data_oe", 16'(ps2data_oe), 16'd0);
        chk("midrst_present", 16'(mouse_present), 16'd0);
        cpu_rd("midrst_x", 16'hFBDF, 8'h00, 1'b0);
        cpu_rd("midrst_y", 16'hFFDF, 8'h00, 1'b0);
        dev_clk = 1'b1;
        dev_data = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
